// File: rtl/sudoku_grid_checker.sv
// sudoku_grid_checker: Sudoku grid store plus sequential validator.
// Cells load row-major while idle. On check_start the engine walks all rows,
// then all columns, then all boxes, one cell per clock. It flags duplicates,
// out-of-range values (row pass only) and empty cells. Only the first
// violation is captured.
// Optional build macro: ERR_LOC_EN adds err_row/err_col, which hold the grid
// coordinates of the first offending cell.
module sudoku_grid_checker #(
    parameter  int BOX   = 3,
    parameter  int VAL_W = 4,
    localparam int SIDE  = BOX * BOX,
    localparam int IDX_W = $clog2(SIDE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [VAL_W-1:0] in_value,
    output logic             in_ready,
    input  logic             check_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_kind,
    output logic [IDX_W-1:0] err_index,
    output logic             incomplete
`ifdef ERR_LOC_EN
    ,
    output logic [IDX_W-1:0] err_row,
    output logic [IDX_W-1:0] err_col
`endif
);

    localparam int NCELL = SIDE * SIDE;
    localparam int PTR_W = $clog2(NCELL);

    localparam logic [1:0] KIND_ROW   = 2'd0;
    localparam logic [1:0] KIND_COL   = 2'd1;
    localparam logic [1:0] KIND_BOX   = 2'd2;
    localparam logic [1:0] KIND_RANGE = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ROWS, S_COLS, S_BOXES} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grp_q, grp_d;
    logic [IDX_W-1:0]   pos_q, pos_d;
    logic [SIDE-1:0]    seen_q, seen_d;
    logic [VAL_W-1:0]   cells_q [NCELL];
    logic [VAL_W-1:0]   cells_d [NCELL];
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               inc_q, inc_d;
    logic [1:0]         kind_q, kind_d;
    logic [IDX_W-1:0]   index_q, index_d;
`ifdef ERR_LOC_EN
    logic [IDX_W-1:0]   row_q, row_d;
    logic [IDX_W-1:0]   col_q, col_d;
`endif

    int                 scan_r;
    int                 scan_c;
    logic [PTR_W-1:0]   scan_addr;
    logic [VAL_W-1:0]   cur_val;
    logic               is_empty;
    logic               is_big;
    logic               is_legal;
    logic [SIDE-1:0]    seen_eff;
    logic [SIDE-1:0]    val_bit;
    logic               is_dup;
    logic               is_viol;
    logic [1:0]         pass_kind;
    logic               last_pos;
    logic               last_grp;

    assign busy       = (state_q != S_IDLE);
    assign in_ready   = (state_q == S_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign incomplete = inc_q;
    assign err_kind   = kind_q;
    assign err_index  = index_q;
`ifdef ERR_LOC_EN
    assign err_row    = row_q;
    assign err_col    = col_q;
`endif

    // Map (group, position) of the current pass to grid coordinates and fetch the cell
    always_comb begin
        scan_r = int'(grp_q);
        scan_c = int'(pos_q);
        case (state_q)
            S_COLS: begin
                scan_r = int'(pos_q);
                scan_c = int'(grp_q);
            end
            S_BOXES: begin
                scan_r = (int'(grp_q) / BOX) * BOX + int'(pos_q) / BOX;
                scan_c = (int'(grp_q) % BOX) * BOX + int'(pos_q) % BOX;
            end
            default: ;
        endcase
        scan_addr = PTR_W'(scan_r * SIDE + scan_c);
        cur_val   = cells_q[scan_addr];
    end

    // Classify the current cell against the per-group seen bitmap
    always_comb begin
        is_empty  = (cur_val == '0);
        is_big    = (cur_val > VAL_W'(SIDE));
        is_legal  = !is_empty && !is_big;
        // The bitmap is treated as empty on the first cell of every group
        seen_eff  = (pos_q == '0) ? '0 : seen_q;
        val_bit   = is_legal ? (SIDE'(1) << (cur_val - VAL_W'(1))) : '0;
        is_dup    = |(seen_eff & val_bit);
        case (state_q)
            S_ROWS:  pass_kind = KIND_ROW;
            S_COLS:  pass_kind = KIND_COL;
            default: pass_kind = KIND_BOX;
        endcase
        is_viol   = (is_big && state_q == S_ROWS) || is_dup;
        last_pos  = (pos_q == IDX_W'(SIDE - 1));
        last_grp  = (grp_q == IDX_W'(SIDE - 1));
    end

    // Next-state logic: loading and command acceptance in IDLE, scanning otherwise
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grp_d   = grp_q;
        pos_d   = pos_q;
        seen_d  = seen_q;
        cells_d = cells_q;
        done_d  = done_q;
        err_d   = err_q;
        inc_d   = inc_q;
        kind_d  = kind_q;
        index_d = index_q;
`ifdef ERR_LOC_EN
        row_d   = row_q;
        col_d   = col_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    cells_d[ptr_q] = in_value;
                    ptr_d   = (ptr_q == PTR_W'(NCELL - 1)) ? '0 : ptr_q + PTR_W'(1);
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    inc_d   = 1'b0;
                    kind_d  = '0;
                    index_d = '0;
`ifdef ERR_LOC_EN
                    row_d   = '0;
                    col_d   = '0;
`endif
                end
                if (check_start) begin
                    state_d = S_ROWS;
                    grp_d   = '0;
                    pos_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    inc_d   = 1'b0;
                    kind_d  = '0;
                    index_d = '0;
`ifdef ERR_LOC_EN
                    row_d   = '0;
                    col_d   = '0;
`endif
                end
            end
            default: begin
                seen_d = seen_eff | val_bit;
                if (is_empty) begin
                    inc_d = 1'b1;
                end
                if (is_viol) begin
                    err_d = 1'b1;
                    // Only the first violation of a check is recorded
                    if (!err_q) begin
                        kind_d  = is_dup ? pass_kind : KIND_RANGE;
                        index_d = grp_q;
`ifdef ERR_LOC_EN
                        row_d   = IDX_W'(scan_r);
                        col_d   = IDX_W'(scan_c);
`endif
                    end
                end
                if (last_pos) begin
                    pos_d = '0;
                    if (last_grp) begin
                        grp_d = '0;
                        case (state_q)
                            S_ROWS:  state_d = S_COLS;
                            S_COLS:  state_d = S_BOXES;
                            default: begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        grp_d = grp_q + IDX_W'(1);
                    end
                end else begin
                    pos_d = pos_q + IDX_W'(1);
                end
            end
        endcase
    end

    // State, grid and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grp_q   <= '0;
            pos_q   <= '0;
            seen_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            inc_q   <= 1'b0;
            kind_q  <= '0;
            index_q <= '0;
            for (int i = 0; i < NCELL; i++) begin
                cells_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grp_q   <= grp_d;
            pos_q   <= pos_d;
            seen_q  <= seen_d;
            done_q  <= done_d;
            err_q   <= err_d;
            inc_q   <= inc_d;
            kind_q  <= kind_d;
            index_q <= index_d;
            cells_q <= cells_d;
        end
    end

`ifdef ERR_LOC_EN
    // Location of the first offending cell
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
`endif

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Bench for sudoku_grid_checker: a 9x9 instance driven from a table of grids,
// plus a 4x4 instance for pointer wrap and same-cycle write/start.
module tb_sudoku_grid_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 9x9 instance
    logic       a_in_valid, a_in_ready, a_check_start, a_busy, a_done, a_err, a_incomplete;
    logic [3:0] a_in_value;
    logic [1:0] a_err_kind;
    logic [3:0] a_err_index;
`ifdef ERR_LOC_EN
    logic [3:0] a_err_row, a_err_col;
`endif

    // 4x4 instance
    logic       b_in_valid, b_in_ready, b_check_start, b_busy, b_done, b_err, b_incomplete;
    logic [3:0] b_in_value;
    logic [1:0] b_err_kind;
    logic [1:0] b_err_index;
`ifdef ERR_LOC_EN
    logic [1:0] b_err_row, b_err_col;
`endif

    sudoku_grid_checker #(.BOX(3), .VAL_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_value(a_in_value), .in_ready(a_in_ready),
        .check_start(a_check_start), .busy(a_busy), .done(a_done), .err(a_err),
        .err_kind(a_err_kind), .err_index(a_err_index), .incomplete(a_incomplete)
`ifdef ERR_LOC_EN
        , .err_row(a_err_row), .err_col(a_err_col)
`endif
    );

    sudoku_grid_checker #(.BOX(2), .VAL_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_value(b_in_value), .in_ready(b_in_ready),
        .check_start(b_check_start), .busy(b_busy), .done(b_done), .err(b_err),
        .err_kind(b_err_kind), .err_index(b_err_index), .incomplete(b_incomplete)
`ifdef ERR_LOC_EN
        , .err_row(b_err_row), .err_col(b_err_col)
`endif
    );

    typedef struct {
        int grid;
        int err;
        int kind;
        int idx;
        int inc;
        int row;
        int col;
    } case_t;

    typedef struct {
        string tag;
        int    err;
        int    kind;
        int    idx;
        int    inc;
        int    row;
        int    col;
        int    lat;
    } exp_t;

    case_t tbl [7];
    exp_t  sbq [$];
    int    g3 [81];
    int    g2 [16];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int base3(input int r, input int c);
        return ((r * 3 + r / 3 + c) % 9) + 1;
    endfunction

    function automatic int base2(input int r, input int c);
        return ((r * 2 + r / 2 + c) % 4) + 1;
    endfunction

    task automatic build3(input int id);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                g3[r*9+c] = (id == 1 || id == 2 || id == 5) ? 0 : base3(r, c);
        case (id)
            1: begin g3[0*9+2] = 5; g3[7*9+2] = 5; end
            2: begin g3[0] = 3; g3[1*9+1] = 3; end
            3: g3[3*9+5] = 12;
            4: begin g3[3*9+5] = 12; g3[4*9+0] = g3[4*9+1]; end
            6: g3[1] = g3[0];
            default: ;
        endcase
    endtask

    task automatic load3();
        for (int i = 0; i < 81; i++) begin
            @(negedge clk);
            if (i == 0) chk("a in_ready idle", a_in_ready, 1);
            a_in_valid = 1'b1;
            a_in_value = 4'(g3[i]);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    // Starts a check on the 9x9 instance and counts edges until done.
    // With disturb set, a second check_start and an in_valid are pulsed mid-scan.
    task automatic start_and_wait3(input bit disturb, output int lat);
        @(negedge clk);
        a_check_start = 1'b1;
        @(posedge clk);
        #1;
        a_check_start = 1'b0;
        chk("a busy after start", a_busy, 1);
        chk("a done cleared by start", a_done, 0);
        lat = 0;
        while (a_done !== 1'b1 && lat < 2000) begin
            a_check_start = (disturb && lat == 50);
            if (disturb && lat == 60) begin
                a_in_valid = 1'b1;
                a_in_value = 4'd7;
                chk("a in_ready while busy", a_in_ready, 0);
            end else begin
                a_in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        a_check_start = 1'b0;
        a_in_valid    = 1'b0;
    endtask

    task automatic compare(input exp_t e, input int lat, input logic dn, input logic bsy,
                           input logic er, input logic inc, input int kind, input int idx,
                           input int row, input int col);
        chk($sformatf("%s latency", e.tag), lat, e.lat);
        chk($sformatf("%s done", e.tag), dn, 1);
        chk($sformatf("%s busy", e.tag), bsy, 0);
        chk($sformatf("%s err", e.tag), er, e.err);
        chk($sformatf("%s incomplete", e.tag), inc, e.inc);
        if (e.err != 0) begin
            chk($sformatf("%s err_kind", e.tag), kind, e.kind);
            chk($sformatf("%s err_index", e.tag), idx, e.idx);
`ifdef ERR_LOC_EN
            chk($sformatf("%s err_row", e.tag), row, e.row);
            chk($sformatf("%s err_col", e.tag), col, e.col);
`endif
        end
        if (row < 0 || col < 0) chk("loc sanity", 0, 1);
    endtask

    task automatic pop_compare_a(input int lat);
        exp_t e;
        int   r, c;
        r = 0;
        c = 0;
`ifdef ERR_LOC_EN
        r = int'(a_err_row);
        c = int'(a_err_col);
`endif
        if (sbq.size() == 0) begin
            chk("a scoreboard empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            compare(e, lat, a_done, a_busy, a_err, a_incomplete,
                    int'(a_err_kind), int'(a_err_index), r, c);
        end
    endtask

    task automatic pop_compare_b(input int lat);
        exp_t e;
        int   r, c;
        r = 0;
        c = 0;
`ifdef ERR_LOC_EN
        r = int'(b_err_row);
        c = int'(b_err_col);
`endif
        if (sbq.size() == 0) begin
            chk("b scoreboard empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            compare(e, lat, b_done, b_busy, b_err, b_incomplete,
                    int'(b_err_kind), int'(b_err_index), r, c);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_value = '0; a_check_start = 1'b0;
        b_in_valid = 1'b0; b_in_value = '0; b_check_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("a reset busy", a_busy, 0);
        chk("a reset done", a_done, 0);
        chk("a reset err", a_err, 0);
        chk("a reset incomplete", a_incomplete, 0);
        chk("a reset err_kind", a_err_kind, 0);
        chk("a reset err_index", a_err_index, 0);
        chk("a reset in_ready", a_in_ready, 1);
        chk("b reset busy", b_busy, 0);
        chk("b reset done", b_done, 0);
`ifdef ERR_LOC_EN
        chk("a reset err_row", a_err_row, 0);
        chk("a reset err_col", a_err_col, 0);
`endif

        //            grid err kind idx inc row col
        tbl[0] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 2, 1, 7, 2};
        tbl[2] = '{2, 1, 2, 0, 1, 1, 1};
        tbl[3] = '{3, 1, 3, 3, 0, 3, 5};
        tbl[4] = '{4, 1, 3, 3, 0, 3, 5};
        tbl[5] = '{5, 0, 0, 0, 1, 0, 0};
        tbl[6] = '{6, 1, 0, 0, 0, 0, 1};

        for (int i = 0; i < 7; i++) begin
            build3(tbl[i].grid);
            load3();
            sbq.push_back('{$sformatf("case%0d", i), tbl[i].err, tbl[i].kind, tbl[i].idx,
                            tbl[i].inc, tbl[i].row, tbl[i].col, 243});
            start_and_wait3(i == 0, lat);
            pop_compare_a(lat);
        end

        // An accepted write clears the sticky results
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_value = 4'd1;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        chk("write clears done", a_done, 0);
        chk("write clears err", a_err, 0);
        chk("write clears incomplete", a_incomplete, 0);

        // Reset mid-check abandons the scan and clears the array
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        build3(0);
        load3();
        @(negedge clk);
        a_check_start = 1'b1;
        @(posedge clk);
        #1;
        a_check_start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid reset busy", a_busy, 0);
        chk("mid reset done", a_done, 0);
        chk("mid reset in_ready", a_in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid reset no late done", a_done, 0);
        sbq.push_back('{"recheck", 0, 0, 0, 1, 0, 0, 243});
        start_and_wait3(1'b0, lat);
        pop_compare_a(lat);

        // 4x4: cell 0 initially wrong, overwritten by the 17th write issued
        // together with check_start; first violation is the row-1 duplicate
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g2[r*4+c] = base2(r, c);
        g2[0] = 4;
        g2[4] = 2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1;
            b_in_value = 4'(g2[i]);
        end
        @(negedge clk);
        b_in_valid    = 1'b1;
        b_in_value    = 4'd1;
        b_check_start = 1'b1;
        sbq.push_back('{"box2", 1, 0, 1, 0, 1, 3, 48});
        @(posedge clk);
        #1;
        b_in_valid    = 1'b0;
        b_check_start = 1'b0;
        chk("b busy after start", b_busy, 1);
        chk("b in_ready while busy", b_in_ready, 0);
        lat = 0;
        while (b_done !== 1'b1 && lat < 500) begin
            @(posedge clk);
            #1;
            lat++;
        end
        pop_compare_b(lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sudoku_grid_checker.md
Name: sudoku_grid_checker

Overview:
Parametrised Sudoku grid store and validator for grids of order BOX (side SIDE = BOX*BOX).
- Load path: cells stream in row-major.
- Check path: on command, a sequential engine scans every row, then every column, then every box, one cell per clock.
- Reports: duplicate values, out-of-range values and empty cells.
- Sits between the pin-level input decoder and the status output mux of the top-level tile.

Parameters:
BOX, 3, box side; grid side SIDE = BOX*BOX (local), BOX in 2..4
VAL_W, 4, cell value width; must satisfy 2**VAL_W > SIDE
IDX_W, derived clog2(SIDE), width of group/row/column indices (local, not overridable)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  load strobe for one cell value
in_value  input  VAL_W  cell value; 0 = empty, 1..SIDE legal
in_ready  output  1  load accepted this cycle (= not busy)
check_start  input  1  request a full-grid check
busy  output  1  check engine scanning
done  output  1  check finished; sticky
err  output  1  at least one violation found in last check; sticky
err_kind  output  2  first violation: 0 row dup, 1 col dup, 2 box dup, 3 range
err_index  output  IDX_W  row/col/box index of first violation
incomplete  output  1  last check saw at least one empty (0) cell
err_row  output  IDX_W  row of first offending cell (ERR_LOC_EN only)
err_col  output  IDX_W  column of first offending cell (ERR_LOC_EN only)

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values: every cell 0; load pointer 0; state IDLE; busy, done, err, incomplete, err_kind, err_index, err_row, err_col all 0.
- Reset mid-check: same as reset; the scan is abandoned and no done is produced.
- States: IDLE -> ROWS -> COLS -> BOXES -> IDLE.
- Load, IDLE only:
  - in_valid & in_ready writes in_value to the cell at the load pointer, then increments the pointer.
  - Pointer wraps after SIDE*SIDE-1 to 0; a further write overwrites cell 0.
  - Any accepted write clears done, err and incomplete.
- Check start:
  - check_start in IDLE is accepted at edge T. busy=1 from T+1.
  - If in_valid is asserted in the same cycle, the write completes first and the scan sees the new value.
  - check_start while busy is ignored.
  - in_ready=0 while busy; in_valid while busy is dropped.
  - Accepting check_start clears done, err and incomplete at the same edge.
- Scan:
  - One cell per cycle, SIDE groups of SIDE cells per pass.
  - Box order: boxes row-major; cells within a box row-major.
  - A SIDE-bit seen bitmap is cleared at the first cell of each group.
- Cell rules:
  - value 0: sets incomplete; no bitmap update.
  - value > SIDE: range violation, checked in the ROWS pass only.
  - otherwise: if the bitmap bit is already set, it is a duplicate of the current pass kind; then set the bit.
- First violation only:
  - err_kind, err_index (group index) and, with ERR_LOC_EN, err_row/err_col are captured.
  - Later violations only keep err=1.
  - Simultaneous events cannot occur: one cell per cycle.
- Latency:
  - Cells are visited in cycles T+1..T+3*SIDE*SIDE.
  - busy falls and done rises at T+3*SIDE*SIDE+1 (BOX=3: T+244; BOX=2: T+49).
- done, err and all captured fields hold until the next accepted write, check_start or rst.
- The scan never modifies the array.

Optional Feature:
ERR_LOC_EN
- Defined:
  - err_row/err_col ports exist and hold the grid coordinates of the first offending cell.
  - For a duplicate, that is the second (repeating) occurrence in scan order.
- Undefined:
  - The ports and their capture registers are absent.
  - err_kind/err_index behaviour is unchanged.

Test Plan:
- BOX=3, load a valid solved grid, check_start at T -> busy T+1..T+243, done=1 at T+244, err=0, incomplete=0.
- Empty grid with 5 at (0,2) and (7,2), check -> err=1, err_kind=1, err_index=2, incomplete=1; with ERR_LOC_EN err_row=7, err_col=2.
- Empty grid with 3 at (0,0) and (1,1) -> err_kind=2, err_index=0; ERR_LOC_EN: err_row=1, err_col=1.
- Solved grid with cell (3,5) set to 12 -> err_kind=3, err_index=3, err_row=3, err_col=5; row-4 duplicate injected too -> fields unchanged, err=1.
- BOX=2, 4x4 grid with duplicate 2 in row 1 -> err_kind=0, err_index=1, done at T+49; 17th write overwrites cell 0.
- rst at T+100 mid-check -> busy=0, done=0 next cycle, array cleared; re-check -> done, err=0, incomplete=1.
